// File: rtl/nibbler_pkg.sv
// Shared types and constants for the Nibbler 4-bit CPU control unit.
package nibbler_pkg;

    typedef enum logic [3:0] {
        OP_JC   = 4'h0,
        OP_JNC  = 4'h1,
        OP_CMPI = 4'h2,
        OP_CMPM = 4'h3,
        OP_LIT  = 4'h4,
        OP_IN   = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_JZ   = 4'h8,
        OP_JNZ  = 4'h9,
        OP_ADDI = 4'hA,
        OP_ADDM = 4'hB,
        OP_JMP  = 4'hC,
        OP_OUT  = 4'hD,
        OP_NORI = 4'hE,
        OP_NORM = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_NOR  = 2'd2,
        ALU_CMP  = 2'd3
    } alu_op_t;

    // Encoding 3 is never produced by the decoder.
    typedef enum logic [1:0] {
        SRC_IMM  = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_IN   = 2'd2,
        SRC_NONE = 2'd3
    } alu_src_t;

    localparam logic PHASE_FETCH = 1'b0;
    localparam logic PHASE_EXEC  = 1'b1;

    // Decoded execute-cycle strobes plus the flag-update controls.
    typedef struct packed {
        logic     pc_inc;
        logic     pc_load;
        logic     accu_we;
        alu_op_t  alu_op;
        alu_src_t alu_src;
        logic     ram_we;
        logic     ram_oe;
        logic [1:0] in_sel;
        logic     c_we;     // carry register takes a new value
        logic     c_clr;    // new carry value is 0 instead of alu_carry
        logic     z_we;     // zero register takes alu_zero
    } strobe_t;

    localparam strobe_t STROBE_IDLE = '0;

    // Branch condition, evaluated on the flags registered before this execute.
    function automatic logic jump_taken(input opcode_t op, input logic c, input logic z);
        logic take;
        take = 1'b0;
        case (op)
            OP_JC:   take = c;
            OP_JNC:  take = ~c;
            OP_JZ:   take = z;
            OP_JNZ:  take = ~z;
            OP_JMP:  take = 1'b1;
            default: take = 1'b0;
        endcase
        return take;
    endfunction

endpackage

// File: rtl/nibbler_if.sv
// Bus between the Nibbler control unit and the rest of the CPU
// (program ROM/PC, ALU/accumulator datapath, RAM and I/O ports).
interface nibbler_if #(
    parameter int NUM_OUT = 3
);
    import nibbler_pkg::*;

    logic [3:0]         instr;
    logic [3:0]         operand;
    logic               alu_carry;
    logic               alu_zero;

    logic               phase;
    logic [3:0]         ir;
    logic               pc_inc;
    logic               pc_load;
    logic               accu_we;
    alu_op_t            alu_op;
    alu_src_t           alu_src;
    logic               ram_we;
    logic               ram_oe;
    logic [NUM_OUT-1:0] out_we;
    logic [1:0]         in_sel;
    logic               carry;
    logic               zero;

    // Control unit side
    modport master (
        input  instr, operand, alu_carry, alu_zero,
        output phase, ir, pc_inc, pc_load, accu_we, alu_op, alu_src,
               ram_we, ram_oe, out_we, in_sel, carry, zero
    );

    // Datapath / program memory side
    modport slave (
        output instr, operand, alu_carry, alu_zero,
        input  phase, ir, pc_inc, pc_load, accu_we, alu_op, alu_src,
               ram_we, ram_oe, out_we, in_sel, carry, zero
    );

endinterface

// File: rtl/nibbler_decode.sv
// Combinational opcode decoder: latched opcode, port select and flags
// in, execute-cycle strobe bundle and one-hot output-port strobe out.
module nibbler_decode
    import nibbler_pkg::*;
#(
    parameter int NUM_OUT = 3
) (
    input  logic [3:0]         ir,
    input  logic [1:0]         sel,
    input  logic               carry,
    input  logic               zero,
    output strobe_t            strobe,
    output logic [NUM_OUT-1:0] out_we
);

    opcode_t op;
    assign op = opcode_t'(ir);

    // Per-opcode strobe decode; every path that is not a taken jump steps the PC.
    always_comb begin
        strobe         = STROBE_IDLE;
        out_we         = '0;
        strobe.pc_inc  = 1'b1;
        case (op)
            OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP: begin
                strobe.pc_load = jump_taken(op, carry, zero);
                strobe.pc_inc  = ~jump_taken(op, carry, zero);
            end
            OP_LIT: begin
                strobe.accu_we = 1'b1;
                strobe.alu_op  = ALU_PASS;
                strobe.alu_src = SRC_IMM;
                strobe.in_sel  = sel;
            end
            OP_LD: begin
                strobe.accu_we = 1'b1;
                strobe.alu_op  = ALU_PASS;
                strobe.alu_src = SRC_RAM;
                strobe.ram_oe  = 1'b1;
                strobe.in_sel  = sel;
            end
            OP_IN: begin
                // Out-of-range ports are still selected; the datapath returns 0.
                strobe.accu_we = 1'b1;
                strobe.alu_op  = ALU_PASS;
                strobe.alu_src = SRC_IN;
                strobe.in_sel  = sel;
            end
            OP_ADDI, OP_ADDM: begin
                strobe.accu_we = 1'b1;
                strobe.alu_op  = ALU_ADD;
                strobe.alu_src = (op == OP_ADDM) ? SRC_RAM : SRC_IMM;
                strobe.ram_oe  = (op == OP_ADDM);
                strobe.c_we    = 1'b1;
                strobe.z_we    = 1'b1;
            end
            OP_NORI, OP_NORM: begin
                strobe.accu_we = 1'b1;
                strobe.alu_op  = ALU_NOR;
                strobe.alu_src = (op == OP_NORM) ? SRC_RAM : SRC_IMM;
                strobe.ram_oe  = (op == OP_NORM);
                strobe.c_we    = 1'b1;
                strobe.c_clr   = 1'b1;
                strobe.z_we    = 1'b1;
            end
            OP_CMPI, OP_CMPM: begin
                // Subtract for flags only; the accumulator keeps its value.
                strobe.alu_op  = ALU_CMP;
                strobe.alu_src = (op == OP_CMPM) ? SRC_RAM : SRC_IMM;
                strobe.ram_oe  = (op == OP_CMPM);
                strobe.c_we    = 1'b1;
                strobe.z_we    = 1'b1;
            end
            OP_ST: begin
                strobe.ram_we  = 1'b1;
            end
            OP_OUT: begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    out_we[i] = (sel == 2'(i));
                end
            end
            default: begin
                strobe.pc_inc = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/nibbler_control.sv
// Nibbler control unit: fetch/execute phase register, instruction
// register, CARRY/ZERO flags, and enable/phase gating of the decoded strobes.
module nibbler_control
    import nibbler_pkg::*;
#(
    parameter int NUM_OUT = 3,
    parameter int NUM_IN  = 3
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      en,
    nibbler_if.master bus
);

    // Port indices share the 2-bit operand field; index 3 is reserved as "no port".
    if (NUM_OUT < 1 || NUM_OUT > 3 || NUM_IN < 1 || NUM_IN > 4) begin : g_param_check
        $error("nibbler_control: NUM_OUT must be 1..3 and NUM_IN 1..4");
    end

    logic               phase_q;
    logic [3:0]         ir_q;
    logic               carry_q;
    logic               zero_q;
    logic               exec_active;
    logic               fetch_active;
    strobe_t            dec;
    logic [NUM_OUT-1:0] dec_out_we;

    assign exec_active  = en && (phase_q == PHASE_EXEC);
    assign fetch_active = en && (phase_q == PHASE_FETCH);

    nibbler_decode #(
        .NUM_OUT (NUM_OUT)
    ) u_decode (
        .ir     (ir_q),
        .sel    (bus.operand[1:0]),
        .carry  (carry_q),
        .zero   (zero_q),
        .strobe (dec),
        .out_we (dec_out_we)
    );

    // Phase toggles each enabled cycle, so every instruction is fetch + execute.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= PHASE_FETCH;
        end else if (en) begin
            phase_q <= ~phase_q;
        end
    end

    // Opcode nibble is captured at the edge that ends fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q <= '0;
        end else if (fetch_active) begin
            ir_q <= bus.instr;
        end
    end

    // Flags update at the edge that ends execute, only for flag-writing opcodes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (exec_active) begin
            if (dec.c_we) begin
                carry_q <= dec.c_clr ? 1'b0 : bus.alu_carry;
            end
            if (dec.z_we) begin
                zero_q <= bus.alu_zero;
            end
        end
    end

    // Strobes are live only in an enabled execute cycle; reset clears the phase, which kills them at once.
    always_comb begin
        bus.pc_inc  = 1'b0;
        bus.pc_load = 1'b0;
        bus.accu_we = 1'b0;
        bus.alu_op  = ALU_PASS;
        bus.alu_src = SRC_IMM;
        bus.ram_we  = 1'b0;
        bus.ram_oe  = 1'b0;
        bus.out_we  = '0;
        bus.in_sel  = 2'b00;
        if (exec_active) begin
            bus.pc_inc  = dec.pc_inc;
            bus.pc_load = dec.pc_load;
            bus.accu_we = dec.accu_we;
            bus.alu_op  = dec.alu_op;
            bus.alu_src = dec.alu_src;
            bus.ram_we  = dec.ram_we;
            bus.ram_oe  = dec.ram_oe;
            bus.out_we  = dec_out_we;
            bus.in_sel  = dec.in_sel;
        end
    end

    assign bus.phase = phase_q;
    assign bus.ir    = ir_q;
    assign bus.carry = carry_q;
    assign bus.zero  = zero_q;

endmodule

// File: tb/tb_nibbler_control.sv
// Self-checking bench for nibbler_control: table of instructions with
// expected execute strobes and post-execute flags, fed through a
// scoreboard queue, plus hand sequences for enable-hold and mid-execute reset.
`timescale 1ns/1ps
module tb_nibbler_control;

    logic clk;
    logic reset;
    logic en;

    nibbler_if #(.NUM_OUT(3)) bus ();

    nibbler_control #(
        .NUM_OUT (3),
        .NUM_IN  (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [3:0] operand;
        logic       ac;
        logic       az;
        logic       pc_inc;
        logic       pc_load;
        logic       accu_we;
        logic [1:0] alu_op;
        logic [1:0] alu_src;
        logic       ram_we;
        logic       ram_oe;
        logic [2:0] out_we;
        logic [1:0] in_sel;
        logic       chk_alu;
        logic       chk_in;
        logic       carry;
        logic       zero;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    vec_t tbl[$];
    vec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] strobes();
        return {bus.pc_inc, bus.pc_load, bus.accu_we, bus.alu_op, bus.alu_src,
                bus.ram_we, bus.ram_oe, bus.out_we, bus.in_sel};
    endfunction

    function automatic vec_t mk(input string name, input logic [3:0] op, input logic [3:0] operand,
                                input logic ac, input logic az,
                                input logic pi, input logic pl, input logic aw,
                                input logic [1:0] aop, input logic [1:0] asrc,
                                input logic rw, input logic roe, input logic [2:0] ow,
                                input logic [1:0] isel, input logic ca, input logic ci,
                                input logic c, input logic z);
        vec_t v;
        v.name = name; v.op = op; v.operand = operand; v.ac = ac; v.az = az;
        v.pc_inc = pi; v.pc_load = pl; v.accu_we = aw; v.alu_op = aop; v.alu_src = asrc;
        v.ram_we = rw; v.ram_oe = roe; v.out_we = ow; v.in_sel = isel;
        v.chk_alu = ca; v.chk_in = ci; v.carry = c; v.zero = z;
        return v;
    endfunction

    // Called at a falling edge in fetch; returns at the falling edge of the next fetch.
    task automatic run_vec(input vec_t v);
        vec_t e;
        check({v.name, ".fetch_phase"}, 32'(bus.phase), 32'(0));
        check({v.name, ".fetch_strobes"}, 32'(strobes()), 32'(0));
        bus.instr     = v.op;
        bus.operand   = v.operand;
        bus.alu_carry = v.ac;
        bus.alu_zero  = v.az;
        sb.push_back(v);
        @(posedge clk);
        #1 bus.instr = ~v.op;
        @(negedge clk);
        if (sb.size() == 0) begin
            check({v.name, ".sb_empty"}, 32'(1), 32'(0));
        end else begin
            e = sb.pop_front();
            check({e.name, ".phase"},   32'(bus.phase),   32'(1));
            check({e.name, ".ir"},      32'(bus.ir),      32'(e.op));
            check({e.name, ".pc_inc"},  32'(bus.pc_inc),  32'(e.pc_inc));
            check({e.name, ".pc_load"}, 32'(bus.pc_load), 32'(e.pc_load));
            check({e.name, ".accu_we"}, 32'(bus.accu_we), 32'(e.accu_we));
            check({e.name, ".ram_we"},  32'(bus.ram_we),  32'(e.ram_we));
            check({e.name, ".ram_oe"},  32'(bus.ram_oe),  32'(e.ram_oe));
            check({e.name, ".out_we"},  32'(bus.out_we),  32'(e.out_we));
            if (e.chk_alu) begin
                check({e.name, ".alu_op"},  32'(bus.alu_op),  32'(e.alu_op));
                check({e.name, ".alu_src"}, 32'(bus.alu_src), 32'(e.alu_src));
            end
            if (e.chk_in) begin
                check({e.name, ".in_sel"}, 32'(bus.in_sel), 32'(e.in_sel));
            end
            @(posedge clk);
            #1;
            check({e.name, ".carry"},      32'(bus.carry), 32'(e.carry));
            check({e.name, ".zero"},       32'(bus.zero),  32'(e.zero));
            check({e.name, ".next_phase"}, 32'(bus.phase), 32'(0));
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected strobes and the flags after each execute, assuming the
        // table runs in order starting from carry=0, zero=0.
        //                name      op     opd    ac az  pi pl aw aop src rw roe ow      is  ca ci  C  Z
        tbl.push_back(mk("lit0",    4'h4, 4'h0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 3'b000, 0, 1, 1, 0, 0));
        tbl.push_back(mk("addi",    4'hA, 4'h3, 1, 1, 1, 0, 1, 1, 0, 0, 0, 3'b000, 0, 1, 0, 1, 1));
        tbl.push_back(mk("nori",    4'hE, 4'h5, 1, 0, 1, 0, 1, 2, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0));
        tbl.push_back(mk("cmpi",    4'h2, 4'h0, 1, 1, 1, 0, 0, 3, 0, 0, 0, 3'b000, 0, 1, 0, 1, 1));
        tbl.push_back(mk("jz_t",    4'h8, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1));
        tbl.push_back(mk("jnz_n",   4'h9, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1));
        tbl.push_back(mk("jc_t",    4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1));
        tbl.push_back(mk("jnc_n",   4'h1, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1));
        tbl.push_back(mk("out1",    4'hD, 4'h1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 1, 1));
        tbl.push_back(mk("out3",    4'hD, 4'h3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1));
        tbl.push_back(mk("out0",    4'hD, 4'hC, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 1, 1));
        tbl.push_back(mk("out2",    4'hD, 4'h2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0, 1, 1));
        tbl.push_back(mk("st",      4'h7, 4'h0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 1, 1));
        tbl.push_back(mk("ld",      4'h6, 4'h0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 3'b000, 0, 1, 1, 1, 1));
        tbl.push_back(mk("in2",     4'h5, 4'hE, 0, 0, 1, 0, 1, 0, 2, 0, 0, 3'b000, 2, 1, 1, 1, 1));
        tbl.push_back(mk("in3",     4'h5, 4'h3, 0, 0, 1, 0, 1, 0, 2, 0, 0, 3'b000, 3, 1, 1, 1, 1));
        tbl.push_back(mk("lit9",    4'h4, 4'h9, 0, 0, 1, 0, 1, 0, 0, 0, 0, 3'b000, 1, 1, 1, 1, 1));
        tbl.push_back(mk("cmpm",    4'h3, 4'h0, 0, 0, 1, 0, 0, 3, 1, 0, 1, 3'b000, 0, 1, 0, 0, 0));
        tbl.push_back(mk("jz_n",    4'h8, 4'h0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
        tbl.push_back(mk("jnz_t",   4'h9, 4'h0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
        tbl.push_back(mk("jc_n",    4'h0, 4'h0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
        tbl.push_back(mk("jnc_t",   4'h1, 4'h0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
        tbl.push_back(mk("addm",    4'hB, 4'h0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 3'b000, 0, 1, 0, 0, 1));
        tbl.push_back(mk("norm",    4'hF, 4'h0, 1, 1, 1, 0, 1, 2, 1, 0, 1, 3'b000, 0, 1, 0, 0, 1));
        tbl.push_back(mk("jmp",     4'hC, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1));
        tbl.push_back(mk("jz_t2",   4'h8, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1));
        tbl.push_back(mk("lit_hold",4'h4, 4'h0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 3'b000, 0, 1, 1, 0, 1));

        reset         = 1'b1;
        en            = 1'b1;
        bus.instr     = 4'hA;
        bus.operand   = 4'h0;
        bus.alu_carry = 1'b1;
        bus.alu_zero  = 1'b1;

        // Reset state: everything held at zero even with en=1 and clocks running.
        @(negedge clk);
        @(negedge clk);
        check("rst.phase",   32'(bus.phase),  32'(0));
        check("rst.ir",      32'(bus.ir),     32'(0));
        check("rst.carry",   32'(bus.carry),  32'(0));
        check("rst.zero",    32'(bus.zero),   32'(0));
        check("rst.strobes", 32'(strobes()),  32'(0));
        reset = 1'b0;

        foreach (tbl[i]) begin
            run_vec(tbl[i]);
        end
        check("sb.drained", 32'(sb.size()), 32'(0));

        // en=0 in fetch: phase and IR hold (IR still holds the last LIT).
        bus.instr     = 4'hB;
        bus.operand   = 4'h0;
        bus.alu_carry = 1'b1;
        bus.alu_zero  = 1'b0;
        en            = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("hold_f.phase", 32'(bus.phase), 32'(0));
        check("hold_f.ir",    32'(bus.ir),    32'(4'h4));
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        // ADDM execute frozen for three cycles.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("hold_x%0d.phase", k),   32'(bus.phase), 32'(1));
            check($sformatf("hold_x%0d.strobes", k), 32'(strobes()), 32'(0));
            check($sformatf("hold_x%0d.carry", k),   32'(bus.carry), 32'(0));
            check($sformatf("hold_x%0d.zero", k),    32'(bus.zero),  32'(1));
            @(posedge clk);
        end
        @(negedge clk);
        en = 1'b1;
        #1;
        check("resume.ir",      32'(bus.ir),      32'(4'hB));
        check("resume.accu_we", 32'(bus.accu_we), 32'(1));
        check("resume.ram_oe",  32'(bus.ram_oe),  32'(1));
        check("resume.alu_op",  32'(bus.alu_op),  32'(1));
        check("resume.pc_inc",  32'(bus.pc_inc),  32'(1));
        @(posedge clk);
        #1;
        check("resume.phase",   32'(bus.phase),   32'(0));
        check("resume.carry",   32'(bus.carry),   32'(1));
        check("resume.zero",    32'(bus.zero),    32'(0));
        check("resume.strobes", 32'(strobes()),   32'(0));

        // Reset pulse in the middle of a taken JC execute.
        @(negedge clk);
        bus.instr     = 4'h0;
        bus.alu_carry = 1'b0;
        bus.alu_zero  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("jc_pre.pc_load", 32'(bus.pc_load), 32'(1));
        #2 reset = 1'b1;
        #0.5;
        check("midrst.pc_load", 32'(bus.pc_load), 32'(0));
        check("midrst.strobes", 32'(strobes()),   32'(0));
        check("midrst.phase",   32'(bus.phase),   32'(0));
        check("midrst.ir",      32'(bus.ir),      32'(0));
        check("midrst.carry",   32'(bus.carry),   32'(0));
        #0.5 reset = 1'b0;
        bus.instr   = 4'h4;
        bus.operand = 4'h0;
        #1;
        check("postrst.phase",   32'(bus.phase), 32'(0));
        check("postrst.strobes", 32'(strobes()), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check("postrst.x_phase",   32'(bus.phase),   32'(1));
        check("postrst.x_accu_we", 32'(bus.accu_we), 32'(1));
        check("postrst.x_pc_inc",  32'(bus.pc_inc),  32'(1));
        @(posedge clk);
        #1;
        check("postrst.carry", 32'(bus.carry), 32'(0));
        check("postrst.zero",  32'(bus.zero),  32'(0));
        check("postrst.phase_end", 32'(bus.phase), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibbler_control.md
Name: nibbler_control

Overview:
- Control unit for the Nibbler 4-bit CPU.
- Runs the two-phase fetch/execute sequence and latches the opcode nibble of the program byte.
- Decodes the 16-opcode ISA into datapath strobes: accumulator, ALU, RAM, ports and PC.
- Owns the CARRY/ZERO flag registers; sits between the program ROM/PC and the accumulator datapath inside NIBBLER.

Parameters:
NUM_OUT, 3, number of output ports (one-hot write strobes).
NUM_IN, 3, number of input ports selectable by IN.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  1 = sequence advances; 0 = freeze phase, IR, flags; all strobes forced inactive
instr  in  4  upper nibble of the current program byte
operand  in  4  lower nibble of the current program byte (port select)
alu_carry  in  1  carry out of the datapath ALU this cycle
alu_zero  in  1  ALU result == 0 this cycle
phase  out  1  0 = fetch, 1 = execute
ir  out  4  latched opcode
pc_inc  out  1  PC += 1 at the next edge
pc_load  out  1  PC <= 12-bit jump target at the next edge
accu_we  out  1  accumulator loads the ALU result at the next edge
alu_op  out  2  0 = PASS, 1 = ADD, 2 = NOR, 3 = CMP (A + ~B + 1, result discarded)
alu_src  out  2  0 = immediate, 1 = RAM data, 2 = input port
ram_we  out  1  write the accumulator to RAM[address]
ram_oe  out  1  RAM drives the data bus
out_we  out  NUM_OUT  one-hot port latch strobe
in_sel  out  2  input port index
carry  out  1  C flag register
zero  out  1  Z flag register

Behaviour:
- Reset (asynchronous, active-high) sets phase=0, ir=0, carry=0, zero=0. All strobes read 0 while reset=1 and remain 0 in the first fetch after release.
- Phase register: toggles on every clk rising edge when en=1. Each instruction takes exactly 2 cycles.
- Fetch (phase=0):
  - ir <= instr at the edge ending fetch.
  - All strobes 0.
- Execute (phase=1): strobes are combinational from ir, operand, carry and zero, and are valid for the whole execute cycle.
  - Datapath and flag registers update at the edge ending execute.
  - Exactly one of pc_inc/pc_load is 1 during execute (en=1).
- Opcode map:
  - 0 JC, 1 JNC, 2 CMPI, 3 CMPM, 4 LIT, 5 IN, 6 LD, 7 ST
  - 8 JZ, 9 JNZ, A ADDI, B ADDM, C JMP, D OUT, E NORI, F NORM
- Jumps (JC/JNC/JZ/JNZ/JMP):
  - Condition uses flag values registered before this execute.
  - Taken: pc_load=1, pc_inc=0. Not taken: pc_inc=1.
  - Flags unchanged.
- LIT / LD / IN:
  - accu_we=1, alu_op=PASS.
  - alu_src = 0 / 1 / 2 respectively; ram_oe=1 for LD.
  - in_sel = operand[1:0].
  - Flags unchanged.
- ADDI / ADDM:
  - accu_we=1, alu_op=ADD, alu_src = 0 / 1; ram_oe=1 for ADDM.
  - carry <= alu_carry, zero <= alu_zero.
- NORI / NORM:
  - accu_we=1, alu_op=NOR.
  - carry <= 0, zero <= alu_zero.
- CMPI / CMPM:
  - accu_we=0, alu_op=CMP.
  - carry <= alu_carry (1 means A >= B, no borrow), zero <= alu_zero (1 means A == B).
- ST: ram_we=1; accumulator and flags unchanged.
- OUT:
  - out_we[operand[1:0]] = 1 when operand[1:0] < NUM_OUT; operand[1:0] = 3 writes nothing.
  - Flags unchanged.
- IN with operand[1:0] >= NUM_IN: in_sel still driven; the datapath returns 0.
- en=0 in either phase:
  - All strobes 0, every register holds.
  - When en returns to 1, the instruction resumes in the phase where it stopped.
- Reset asserted mid-execute:
  - Strobes drop immediately.
  - Flag updates and the PC step for that instruction are lost.
  - Restart from fetch.
- At most one of accu_we, ram_we, or any out_we bit is 1 in a given cycle.

Decomposition:
- Shared package nibbler_pkg holds:
  - opcode enum (4-bit, values as in the opcode map);
  - alu_op_t and alu_src_t enums;
  - the PHASE_FETCH/PHASE_EXEC constants.
- Natural sub-module: nibbler_decode, purely combinational, from (ir, operand, carry, zero) to the strobe bundle.
- The top level holds the phase, IR and flag registers plus en/phase gating.

Test Plan:
- Reset then en=1, instr=4 (LIT): cycle 0 phase=0 with strobes 0; cycle 1 phase=1, accu_we=1, alu_src=0, pc_inc=1; carry=0, zero=0.
- ADDI with alu_carry=1, alu_zero=1 in execute -> carry=1, zero=1 after the edge; a following NORI with alu_zero=0 -> carry=0, zero=0.
- CMPI with alu_zero=1, alu_carry=1 -> accu_we=0, zero=1; next JZ -> pc_load=1, pc_inc=0; next JNZ -> pc_inc=1.
- OUT with operand=0001 -> out_we=010; operand=0011 -> out_we=000; ST -> ram_we=1, out_we=000, accu_we=0.
- en=0 held 3 cycles in execute of ADDM -> phase stays 1, all strobes 0, flags hold; en=1 -> accu_we=1, ram_oe=1 for one cycle, then phase=0.
- Reset pulsed for 1 ns mid-execute of JC with carry=1 -> pc_load drops immediately; phase=0, ir=0, carry=0 after release; no strobe until the next execute.
